// File: rtl/io_input_ctrl_if.sv
// Load/store bus between the LSU IO decode and the input peripheral.
// The LSU is the master; the peripheral answers with combinational hit/read data.
interface io_input_ctrl_if;
  logic        i_re;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_hit;

  modport master (
    output i_re, i_we, i_addr, i_wdata,
    input  o_rdata, o_hit
  );

  modport slave (
    input  i_re, i_we, i_addr, i_wdata,
    output o_rdata, o_hit
  );
endinterface

// File: rtl/io_input_ctrl.sv
// Switch/button input peripheral: 2-flop sync, debounce, sticky W1C edge events
// with a maskable registered interrupt, and a combinational 4-register read port.
module io_input_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'h1001_0000,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic          i_clk,
  input  logic          rst,
  io_input_ctrl_if.slave bus,
  input  logic [31:0]   i_io_sw,
  input  logic [3:0]    i_io_btn,
  output logic          o_irq
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [31:0]         sw_sync_p0, sw_sync_p1, sw_prev, sw_stable, sw_stable_nxt;
  logic [CW-1:0]       sw_cnt, sw_cnt_nxt;
  logic [3:0]          btn_sync_p0, btn_sync_p1, btn_lvl, btn_stable, btn_stable_nxt;
  logic [3:0][CW-1:0]  btn_cnt, btn_cnt_nxt;
  logic [7:0]          evt, evt_set, evt_clr, evt_nxt, irq_en;
  logic [29:0]         off;
  logic [1:0]          sel;
  logic                wr;
  logic                unused_bits;

  // Window decode on word addresses so a base that is not 16-byte aligned still works
  assign off         = bus.i_addr[31:2] - BASE_ADDR[31:2];
  assign bus.o_hit   = (off[29:2] == 28'h0);
  assign sel         = off[1:0];
  assign wr          = bus.i_we && bus.o_hit;
  assign unused_bits = ^{bus.i_addr[1:0], bus.i_wdata[31:8]};

  always_comb begin
    bus.o_rdata = 32'h0;
    if (bus.i_re && bus.o_hit) begin
      case (sel)
        2'd0:    bus.o_rdata = sw_stable;
        2'd1:    bus.o_rdata = {28'h0, btn_stable};
        2'd2:    bus.o_rdata = {24'h0, evt};
        default: bus.o_rdata = {24'h0, irq_en};
      endcase
    end
  end

  assign btn_lvl = ~btn_sync_p1;

  always_comb begin
    btn_stable_nxt = btn_stable;
    btn_cnt_nxt    = '0;
    for (int i = 0; i < 4; i++) begin
      if (btn_lvl[i] != btn_stable[i]) begin
        if (btn_cnt[i] == CNT_MAX) btn_stable_nxt[i] = btn_lvl[i];
        else                       btn_cnt_nxt[i]    = btn_cnt[i] + CNT_ONE;
      end
    end
  end

  // The shared switch counter only advances while the synced vector holds still
  always_comb begin
    sw_stable_nxt = sw_stable;
    sw_cnt_nxt    = '0;
    if ((sw_sync_p1 != sw_stable) && (sw_sync_p1 == sw_prev)) begin
      if (sw_cnt == CNT_MAX) sw_stable_nxt = sw_sync_p1;
      else                   sw_cnt_nxt    = sw_cnt + CNT_ONE;
    end
  end

  // A newly detected edge outranks a same-cycle W1C clear of that bit
  always_comb begin
    evt_set = {btn_stable & ~btn_stable_nxt, ~btn_stable & btn_stable_nxt};
    evt_clr = (wr && (sel == 2'd2)) ? bus.i_wdata[7:0] : 8'h0;
    evt_nxt = (evt & ~evt_clr) | evt_set;
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
      sw_prev     <= '0;
      sw_stable   <= '0;
      sw_cnt      <= '0;
      btn_sync_p0 <= '1;
      btn_sync_p1 <= '1;
      btn_stable  <= '0;
      btn_cnt     <= '0;
      evt         <= '0;
      irq_en      <= '0;
      o_irq       <= 1'b0;
    end else begin
      sw_sync_p0  <= i_io_sw;
      sw_sync_p1  <= sw_sync_p0;
      sw_prev     <= sw_sync_p1;
      sw_stable   <= sw_stable_nxt;
      sw_cnt      <= sw_cnt_nxt;
      btn_sync_p0 <= i_io_btn;
      btn_sync_p1 <= btn_sync_p0;
      btn_stable  <= btn_stable_nxt;
      btn_cnt     <= btn_cnt_nxt;
      evt         <= evt_nxt;
      if (wr && (sel == 2'd3)) irq_en <= bus.i_wdata[7:0];
      o_irq       <= |(evt & irq_en);
    end
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed bench for io_input_ctrl: one instance at the default debounce length
// for the reset/switch timing, one at DEBOUNCE_CYCLES=4 for the remaining behaviour.
module tb_io_input_ctrl;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam logic [31:0] A_SW  = BASE;
  localparam logic [31:0] A_BTN = BASE + 32'h4;
  localparam logic [31:0] A_EVT = BASE + 32'h8;
  localparam logic [31:0] A_IEN = BASE + 32'hC;

  logic        i_clk = 1'b0;
  logic        rst;
  logic [31:0] sw;
  logic [3:0]  btn;
  logic        irq16, irq4;
  int          checks = 0;
  int          errors = 0;

  io_input_ctrl_if bus16();
  io_input_ctrl_if bus4();

  always #5 i_clk = ~i_clk;

  io_input_ctrl #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(16)) dut16 (
    .i_clk(i_clk), .rst(rst), .bus(bus16), .i_io_sw(sw), .i_io_btn(btn), .o_irq(irq16)
  );

  io_input_ctrl #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(4)) dut4 (
    .i_clk(i_clk), .rst(rst), .bus(bus4), .i_io_sw(sw), .i_io_btn(btn), .o_irq(irq4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic rd4(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus4.i_addr = a;
    bus4.i_re   = 1'b1;
    #1;
    d = bus4.o_rdata;
    h = bus4.o_hit;
    bus4.i_re = 1'b0;
  endtask

  task automatic exp4(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    rd4(a, d, h);
    chk(tag, d, exp);
  endtask

  task automatic exp16(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus16.i_addr = a;
    bus16.i_re   = 1'b1;
    #1;
    chk(tag, bus16.o_rdata, exp);
    bus16.i_re = 1'b0;
  endtask

  task automatic wr4(input logic [31:0] a, input logic [31:0] d);
    bus4.i_addr  = a;
    bus4.i_wdata = d;
    bus4.i_we    = 1'b1;
    @(negedge i_clk);
    bus4.i_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        h;
    bus16.i_re = 0; bus16.i_we = 0; bus16.i_addr = BASE; bus16.i_wdata = 0;
    bus4.i_re  = 0; bus4.i_we  = 0; bus4.i_addr  = BASE; bus4.i_wdata  = 0;
    rst = 1'b0;
    btn = 4'hF;
    sw  = 32'hA5A5_A5A5;

    // Reset held for three edges, released between edges
    step(3);
    rst = 1'b1;
    chk("rst_irq16", {31'h0, irq16}, 32'h0);
    chk("rst_irq4", {31'h0, irq4}, 32'h0);
    exp16("rst_evt16", A_EVT, 32'h0);
    exp4("rst_evt4", A_EVT, 32'h0);
    exp4("rst_ien4", A_IEN, 32'h0);
    step(18);
    exp16("rst_sw_e18", A_SW, 32'h0);
    step(1);
    exp16("rst_sw_e19", A_SW, 32'hA5A5_A5A5);
    exp4("rst_sw4", A_SW, 32'hA5A5_A5A5);
    exp4("rst_btn4", A_BTN, 32'h0);

    // Press/release of button 2
    btn = 4'hB;
    step(5);
    exp4("press_btn_k4", A_BTN, 32'h0);
    step(1);
    exp4("press_btn_k5", A_BTN, 32'h4);
    exp4("press_evt", A_EVT, 32'h04);
    step(4);
    btn = 4'hF;
    step(5);
    exp4("rel_btn_k4", A_BTN, 32'h4);
    step(1);
    exp4("rel_btn_k5", A_BTN, 32'h0);
    exp4("rel_evt", A_EVT, 32'h44);
    wr4(A_EVT, 32'h04);
    exp4("w1c_evt", A_EVT, 32'h40);
    wr4(A_EVT, 32'h40);
    exp4("w1c_evt_all", A_EVT, 32'h0);
    chk("pr_irq_off", {31'h0, irq4}, 32'h0);

    // Short button glitch and a chattering switch bit
    btn = 4'hE;
    step(3);
    btn = 4'hF;
    step(10);
    exp4("glitch_btn", A_BTN, 32'h0);
    exp4("glitch_evt", A_EVT, 32'h0);
    for (int i = 0; i < 8; i++) begin
      sw = sw ^ 32'h1;
      step(2);
      exp4($sformatf("sw_chatter%0d", i), A_SW, 32'hA5A5_A5A5);
    end
    sw = 32'h0000_00FF;
    step(6);
    exp4("sw_chg_e6", A_SW, 32'hA5A5_A5A5);
    step(1);
    exp4("sw_chg_e7", A_SW, 32'h0000_00FF);

    // Interrupt masking and timing
    wr4(A_IEN, 32'h01);
    btn = 4'hE;
    step(6);
    exp4("irq_evt_set", A_EVT, 32'h01);
    chk("irq_e6", {31'h0, irq4}, 32'h0);
    step(1);
    chk("irq_e7", {31'h0, irq4}, 32'h1);
    wr4(A_EVT, 32'h01);
    chk("irq_clr_n", {31'h0, irq4}, 32'h1);
    step(1);
    chk("irq_clr_n1", {31'h0, irq4}, 32'h0);
    wr4(A_IEN, 32'h10);
    btn = 4'hF;
    step(6);
    exp4("irq_rel_evt", A_EVT, 32'h10);
    chk("irq_rel_e6", {31'h0, irq4}, 32'h0);
    step(1);
    chk("irq_rel_e7", {31'h0, irq4}, 32'h1);
    wr4(A_EVT, 32'h10);
    step(1);
    chk("irq_rel_clr", {31'h0, irq4}, 32'h0);
    btn = 4'hE;
    step(7);
    exp4("irq_mask_evt", A_EVT, 32'h01);
    chk("irq_masked", {31'h0, irq4}, 32'h0);
    btn = 4'hF;
    step(7);
    chk("irq_rel_again", {31'h0, irq4}, 32'h1);
    wr4(A_EVT, 32'hFF);
    wr4(A_IEN, 32'h00);
    chk("irq_final", {31'h0, irq4}, 32'h0);

    // W1C on the same edge the press event sets
    btn = 4'hD;
    step(5);
    wr4(A_EVT, 32'h02);
    exp4("collide_evt", A_EVT, 32'h02);
    wr4(A_EVT, 32'h02);
    exp4("collide_clr", A_EVT, 32'h0);
    btn = 4'hF;
    step(7);
    wr4(A_EVT, 32'hFF);
    exp4("collide_done", A_EVT, 32'h0);

    // Address decode
    wr4(A_IEN, 32'h5A);
    exp4("dec_ien", A_IEN, 32'h5A);
    rd4(BASE + 32'h10, d, h);
    chk("dec_hi_hit", {31'h0, h}, 32'h0);
    chk("dec_hi_data", d, 32'h0);
    rd4(BASE - 32'h4, d, h);
    chk("dec_lo_hit", {31'h0, h}, 32'h0);
    chk("dec_lo_data", d, 32'h0);
    wr4(BASE + 32'h10, 32'hFFFF_FFFF);
    wr4(BASE - 32'h4, 32'hFFFF_FFFF);
    exp4("dec_ien_kept", A_IEN, 32'h5A);
    wr4(A_IEN, 32'hFFFF_FFFF);
    exp4("dec_ien_mask", A_IEN, 32'h0000_00FF);
    wr4(A_SW, 32'hDEAD_BEEF);
    wr4(A_BTN, 32'hDEAD_BEEF);
    exp4("dec_sw_ro", A_SW, 32'h0000_00FF);
    exp4("dec_btn_ro", A_BTN, 32'h0);
    bus4.i_addr = A_SW;
    #1;
    chk("dec_nore_data", bus4.o_rdata, 32'h0);
    chk("dec_nore_hit", {31'h0, bus4.o_hit}, 32'h1);
    step(1);
    wr4(A_IEN, 32'h0);

    // Reset in the middle of a button debounce
    btn = 4'h7;
    step(4);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    exp4("mid_rst_btn", A_BTN, 32'h0);
    exp4("mid_rst_evt", A_EVT, 32'h0);
    exp4("mid_rst_sw", A_SW, 32'h0);
    step(6);
    exp4("mid_rst_btn_again", A_BTN, 32'h8);
    exp4("mid_rst_evt_again", A_EVT, 32'h08);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_input_ctrl.md
# io_input_ctrl

Memory-mapped input peripheral that responds to the CPU load/store unit bus (`i_we`/`i_re`/`i_addr`/`i_wdata`/`o_rdata`) for the board switches and push-buttons. Raw inputs are synchronised and debounced. Button press and release edges are latched as sticky, write-1-to-clear events with a maskable interrupt. It sits on the LSU's IO decode, and its read data is combinational so that single-cycle loads complete in the issuing cycle.

## Interface
- `BASE_ADDR`, default 32'h1001_0000: word-aligned base of the 16-byte register window.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a new input level. Legal range is ≥ 2.
- `i_clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-low.
- `i_re`  in  1: load strobe from the LSU.
- `i_we`  in  1: store strobe from the LSU.
- `i_addr`  in  32: byte address. Bits [1:0] are ignored.
- `i_wdata`  in  32: store data.
- `o_rdata`  out  32: load data. Combinational.
- `o_hit`  out  1: `i_addr` is inside the window (`BASE_ADDR`..`BASE_ADDR`+0xF). Combinational.
- `i_io_sw`  in  32: raw switches, asynchronous, 1 = on.
- `i_io_btn`  in  4: raw buttons, asynchronous, active-low (0 = pressed).
- `o_irq`  out  1: registered interrupt request.

## Operation
- **Register map** (offset from `BASE_ADDR`):
  - 0x0 SW (RO): debounced switch vector.
  - 0x4 BTN (RO): bits [3:0] are the debounced button levels, 1 = pressed. Bits [31:4] read 0.
  - 0x8 EVT (W1C): bits [3:0] are sticky press events, bits [7:4] are sticky release events. Bits [31:8] read 0.
  - 0xC IRQ_EN (RW): bits [7:0] are the enable mask for EVT. Bits [31:8] read 0 and are write-ignored.
- **Reads:**
  - `o_rdata` = selected register when `i_re && o_hit`, otherwise 32'h0.
  - Reads have no side effects.
- **Writes:**
  - A write takes effect at the `i_clk` edge when `i_we && o_hit`.
  - Writes to SW and BTN are ignored.
  - EVT: each bit written with 1 clears that bit. Bits written with 0 are unchanged.
  - Out-of-window accesses have no effect.
- **Synchronisers:** a 2-flop synchroniser on all 36 raw inputs. The buttons are inverted after sync, so internal 1 = pressed.
- **Button debounce:** one counter per button, each of width $clog2(`DEBOUNCE_CYCLES`).
  - When the synced value ≠ the stable value: if cnt == `DEBOUNCE_CYCLES`-1, then stable <= synced and cnt <= 0; else cnt++.
  - When the synced value == the stable value, cnt <= 0.
- **Switch debounce:** a single shared counter with the same rule, applied to the whole 32-bit vector.
  - The stable vector is loaded from the synced vector after `DEBOUNCE_CYCLES` consecutive cycles in which the synced vector ≠ stable and the synced vector is unchanged from the previous cycle.
  - Any change in the synced vector restarts the count.
- **Events:**
  - On the edge where a button's stable value goes 0→1, EVT[i] is set.
  - On the edge where it goes 1→0, EVT[4+i] is set.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- **Interrupt:** `o_irq` <= |(EVT & IRQ_EN[7:0]), registered from the current register values.

## Timing
- **Reset values:**
  - `o_irq` = 0, EVT = 0, IRQ_EN = 0, SW stable = 0, BTN stable = 0 (released).
  - Switch sync flops = 0. Button sync flops = 1 (raw released), so reset exit raises no spurious event.
  - All counters = 0.
  - `o_rdata` and `o_hit` are combinational and need no reset.
- Reset asserted mid-debounce or mid-event discards the count and flags at the next edge.
- Let edge k be the first edge that samples a new raw level held steady. Then:
  - sync stage 2 updates at edge k+1;
  - the stable level updates at edge k+1+`DEBOUNCE_CYCLES`;
  - the EVT bit sets at that same edge;
  - `o_irq` asserts at edge k+2+`DEBOUNCE_CYCLES` if enabled.
- A raw pulse shorter than `DEBOUNCE_CYCLES` cycles (after sync) never changes the stable value.
- Load data is valid in the same cycle that `i_re` and `i_addr` are presented. There are zero wait states.
- Clearing the last enabled EVT bit at edge n drops `o_irq` at edge n+1.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `i_io_btn`=4'hF and `i_io_sw`=32'hA5A5_A5A5, then release. Required:
  - `o_irq`=0 and EVT reads 0;
  - SW reads 32'hA5A5_A5A5 at edge 3+16 after release and not before.
- **Press/release:** `DEBOUNCE_CYCLES`=4, `i_io_btn`[2] 1→0 held 10 cycles, then 0→1. Required:
  - BTN reads 4'h4 exactly at k+5;
  - EVT reads 32'h04 after the press and 32'h44 after the release;
  - W1C write of 32'h04 leaves 32'h40.
- **Glitch rejection:** `DEBOUNCE_CYCLES`=4, `i_io_btn`[0] low for 3 cycles, then high. Required:
  - BTN stays 0, EVT stays 0.
  - A switch bit toggling every 2 cycles never updates SW.
- **IRQ:** IRQ_EN=32'h01, press button 0. Required:
  - `o_irq`=1 one edge after EVT[0] sets;
  - with IRQ_EN=32'h10, a button-0 press leaves `o_irq`=0 and a release sets it;
  - W1C clear drops `o_irq` one edge later.
- **Collision:** issue a W1C of EVT[1] on the same edge the button-1 press event sets. Required: EVT[1]=1.
- **Decode:** accesses to `BASE_ADDR`+0x10 and `BASE_ADDR`-4 give `o_hit`=0, `o_rdata`=0, and no register change. A write of 32'hFFFF_FFFF to 0xC reads back 32'h0000_00FF. Writes to 0x0 and 0x4 are ignored.
